daq_frame_checker: RTL and testbench

Receive-side parser and checker for the 19-bit ALCT DAQ readout stream. It sits at the far end of the DAQ output (test-board capture / loopback path). It delimits frames by header and trailer markers, extracts header fields, and re-emits the LCT (best1/best2) words in original 11-bit form. It validates frame structure, word count and readout-count continuity, and keeps frame and error statistics.

---
 rtl/daq_frame_checker.sv | 228 ++++++++++++++++++++++
 tb/tb_daq_frame_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_frame_checker.sv
// Receive-side parser/checker for the 19-bit ALCT DAQ readout stream: frame delimiting,
// header field capture, LCT word reconstruction, structural checks and statistics.
module daq_frame_checker (
    input  logic        clk,
    input  logic        hard_rst,
    input  logic [18:0] daq_in,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [4:0]  err,
    output logic [11:0] bxn_hdr,
    output logic [11:0] l1a_cnt_hdr,
    output logic [11:0] rdout_cnt_hdr,
    output logic [11:0] bxn_lct,
    output logic        cfg_rep,
    output logic        zero_sup,
    output logic [3:0]  lct_bins,
    output logic [4:0]  raw_bins,
    output logic        lct_we,
    output logic [10:0] lct_data,
    output logic [10:0] word_cnt,
    output logic [15:0] frames,
    output logic [15:0] errors
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_HDR  = 4'd1,
        ST_CFG  = 4'd2,
        ST_LCT  = 4'd3,
        ST_LPAD = 4'd4,
        ST_RAW  = 4'd5,
        ST_CRC1 = 4'd6,
        ST_CRC2 = 4'd7,
        ST_LAST = 4'd8
    } state_t;

    localparam logic [18:0] HDR_WORD  = 19'h0DB0A;
    localparam logic [18:0] TRL_WORD  = 19'h0DE0D;
    localparam logic [5:0]  CFG_WORDS = 6'd44;
    localparam logic [10:0] WC_MAX    = 11'd2047;

    state_t      state_r, state_s;
    logic [10:0] wc_r, wc_s, wc_inc_s;
    logic [5:0]  cnt_r, cnt_s;
    logic [4:0]  err_acc_r, err_s;
    logic [11:0] prev_rd_r;
    logic        prev_vld_r;
    logic        accept_s, done_s, abort_s, lct_we_s, lct_good_s;
    logic [3:0]  bins_s;

    // next-state, per-frame error accumulation and strobes
    always_comb begin
        state_s    = state_r;
        wc_s       = wc_r;
        cnt_s      = cnt_r;
        err_s      = err_acc_r;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        lct_we_s   = 1'b0;
        accept_s   = ~daq_in[18];
        wc_inc_s   = (wc_r == WC_MAX) ? WC_MAX : wc_r + 11'd1;
        bins_s     = (daq_in[8:5] == 4'd0) ? 4'd0 : daq_in[8:5] - 4'd1;
        lct_good_s = (daq_in[17:12] == 6'd0) && (daq_in[4] == 1'b0);
        if (state_r == ST_IDLE) begin
            if (accept_s && (daq_in == HDR_WORD)) begin
                state_s = ST_HDR;
                wc_s    = 11'd1;
                err_s   = 5'd0;
            end else begin
                state_s = ST_IDLE;
            end
        end else if (!accept_s) begin
            err_s[1] = 1'b1;
            done_s   = 1'b1;
            abort_s  = 1'b1;
            state_s  = ST_IDLE;
        end else begin
            wc_s     = wc_inc_s;
            // reaching the word-count ceiling outside the trailer slot means no valid trailer
            err_s[3] = err_s[3] | ((wc_inc_s == WC_MAX) && (state_r != ST_LAST));
            case (state_r)
                ST_HDR: begin
                    case (wc_inc_s)
                        11'd2, 11'd3: err_s[0] = err_s[0] | (daq_in[18:12] != 7'h0D);
                        11'd4: begin
                            err_s[0] = err_s[0] | (daq_in[18:12] != 7'h0D);
                            err_s[4] = err_s[4] | (prev_vld_r && (daq_in[11:0] != (prev_rd_r + 12'd1)));
                        end
                        11'd5: err_s[0] = err_s[0] | (daq_in[18:15] != 4'd0);
                        11'd6: err_s[0] = err_s[0] | (daq_in[18:13] != 6'd0);
                        11'd7: err_s[0] = err_s[0] | (daq_in != 19'h00062);
                        11'd8: begin
                            err_s[0] = err_s[0] | (daq_in[18:9] != 10'h005);
                            if (cfg_rep) begin
                                state_s = ST_CFG;
                                cnt_s   = CFG_WORDS;
                            end else if (bins_s != 4'd0) begin
                                state_s = ST_LCT;
                                cnt_s   = {1'b0, bins_s, 1'b0};
                            end else begin
                                state_s = ST_RAW;
                            end
                        end
                        default: state_s = ST_HDR;
                    endcase
                end
                ST_CFG: begin
                    cnt_s = cnt_r - 6'd1;
                    if (cnt_r == 6'd1) begin
                        if (lct_bins != 4'd0) begin
                            state_s = ST_LCT;
                            cnt_s   = {1'b0, lct_bins, 1'b0};
                        end else begin
                            state_s = ST_RAW;
                        end
                    end else begin
                        state_s = ST_CFG;
                    end
                end
                ST_LCT: begin
                    cnt_s    = cnt_r - 6'd1;
                    lct_we_s = lct_good_s;
                    err_s[2] = err_s[2] | ~lct_good_s;
                    if (cnt_r == 6'd1) begin
                        state_s = ST_LPAD;
                        cnt_s   = 6'd2;
                    end else begin
                        state_s = ST_LCT;
                    end
                end
                ST_LPAD: begin
                    cnt_s    = cnt_r - 6'd1;
                    err_s[2] = err_s[2] | (daq_in[17:0] != 18'd0);
                    if (cnt_r == 6'd1) begin
                        state_s = ST_RAW;
                    end else begin
                        state_s = ST_LPAD;
                    end
                end
                ST_RAW: begin
                    if (daq_in == TRL_WORD) begin
                        state_s = ST_CRC1;
                    end else begin
                        state_s = ST_RAW;
                    end
                end
                ST_CRC1: state_s = ST_CRC2;
                ST_CRC2: state_s = ST_LAST;
                ST_LAST: begin
                    err_s[3] = err_s[3] | (daq_in[18:11] != 8'h3A) | (daq_in[10:0] != wc_inc_s);
                    done_s   = 1'b1;
                    state_s  = ST_IDLE;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // state, accumulators, header capture and all registered outputs
    always_ff @(posedge clk) begin
        if (!hard_rst) begin
            state_r       <= ST_IDLE;
            wc_r          <= 11'd0;
            cnt_r         <= 6'd0;
            err_acc_r     <= 5'd0;
            prev_rd_r     <= 12'd0;
            prev_vld_r    <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err           <= 5'd0;
            bxn_hdr       <= 12'd0;
            l1a_cnt_hdr   <= 12'd0;
            rdout_cnt_hdr <= 12'd0;
            bxn_lct       <= 12'd0;
            cfg_rep       <= 1'b0;
            zero_sup      <= 1'b0;
            lct_bins      <= 4'd0;
            raw_bins      <= 5'd0;
            lct_we        <= 1'b0;
            lct_data      <= 11'd0;
            word_cnt      <= 11'd0;
            frames        <= 16'd0;
            errors        <= 16'd0;
        end else begin
            state_r    <= state_s;
            wc_r       <= wc_s;
            cnt_r      <= cnt_s;
            err_acc_r  <= err_s;
            frame_done <= done_s;
            lct_we     <= lct_we_s;
            if (lct_we_s) begin
                lct_data <= {daq_in[11:5], daq_in[0], daq_in[3:1]};
            end
            if (done_s) begin
                err      <= err_s;
                frame_ok <= (err_s == 5'd0);
                word_cnt <= wc_s;
                frames   <= (frames == 16'hFFFF) ? frames : frames + 16'd1;
                if (err_s != 5'd0) begin
                    errors <= (errors == 16'hFFFF) ? errors : errors + 16'd1;
                end
            end
            // aborted frames leave the continuity reference untouched
            if (done_s && !abort_s) begin
                prev_rd_r  <= rdout_cnt_hdr;
                prev_vld_r <= 1'b1;
            end
            if ((state_r == ST_HDR) && accept_s) begin
                case (wc_inc_s)
                    11'd2: bxn_hdr       <= daq_in[11:0];
                    11'd3: l1a_cnt_hdr   <= daq_in[11:0];
                    11'd4: rdout_cnt_hdr <= daq_in[11:0];
                    11'd5: begin
                        bxn_lct <= daq_in[11:0];
                        cfg_rep <= daq_in[14];
                    end
                    11'd6: zero_sup <= daq_in[12];
                    11'd8: begin
                        lct_bins <= bins_s;
                        raw_bins <= daq_in[4:0];
                    end
                    default: bxn_hdr <= bxn_hdr;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_daq_frame_checker.sv
// Self-checking bench for daq_frame_checker: frames are built from per-frame settings and the
// expected results are derived from those settings at frame level, then compared by a monitor.
module tb_daq_frame_checker;

    logic        clk = 1'b0;
    logic        hard_rst;
    logic [18:0] daq_in;
    logic        frame_done, frame_ok, cfg_rep, zero_sup, lct_we;
    logic [4:0]  err, raw_bins;
    logic [11:0] bxn_hdr, l1a_cnt_hdr, rdout_cnt_hdr, bxn_lct;
    logic [3:0]  lct_bins;
    logic [10:0] lct_data, word_cnt;
    logic [15:0] frames, errors;

    always #5 clk = ~clk;

    daq_frame_checker dut (
        .clk(clk), .hard_rst(hard_rst), .daq_in(daq_in),
        .frame_done(frame_done), .frame_ok(frame_ok), .err(err),
        .bxn_hdr(bxn_hdr), .l1a_cnt_hdr(l1a_cnt_hdr), .rdout_cnt_hdr(rdout_cnt_hdr),
        .bxn_lct(bxn_lct), .cfg_rep(cfg_rep), .zero_sup(zero_sup),
        .lct_bins(lct_bins), .raw_bins(raw_bins), .lct_we(lct_we), .lct_data(lct_data),
        .word_cnt(word_cnt), .frames(frames), .errors(errors)
    );

    typedef struct {
        logic [4:0]  err;
        logic [10:0] wc;
        logic        hchk;
        logic [11:0] bxn, l1a, rd, bxl;
        logic        cfg, zs;
        logic [3:0]  lb;
        logic [4:0]  rb;
        logic [15:0] fr, er;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] lct_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] m_prev = 12'd0;
    logic        m_pvalid = 1'b0;
    logic [15:0] m_frames = 16'd0;
    logic [15:0] m_errors = 16'd0;
    int k_rd, k_cfg, k_nl, k_b1, k_nraw, k_badhdr, k_badlct, k_badpad, k_badlast, k_mode, k_cut, k_gap;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic send(input logic [18:0] w);
        daq_in = w;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_defaults(input int rd);
        k_rd = rd; k_cfg = 0; k_nl = 0; k_b1 = 0; k_nraw = 0; k_badhdr = 0; k_badlct = 0;
        k_badpad = 0; k_badlast = 0; k_mode = 0; k_cut = 0; k_gap = 1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_frames"}, 32'(frames), 32'd0);
        check_val({tag, "_errors"}, 32'(errors), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
        check_val({tag, "_done"}, 32'(frame_done), 32'd0);
        check_val({tag, "_wc"}, 32'(word_cnt), 32'd0);
        check_val({tag, "_bxn"}, 32'(bxn_hdr), 32'd0);
    endtask

    // builds one frame from the k_* settings, queues its expected outcome, then drives it
    task automatic run_frame();
        logic [18:0] w[$];
        logic [10:0] lexp[$];
        int          lpos[$];
        logic [11:0] bxn, l1a, bxl, rd, nx;
        logic        zs;
        logic [3:0]  field, lo;
        logic [4:0]  rb, ev;
        logic [6:0]  d7;
        logic [18:0] r;
        logic [10:0] n11;
        int          n, sent, cut, p_lct, p_pad;
        logic        aborted;
        exp_t        e;
        bxn = 12'($urandom); l1a = 12'($urandom); bxl = 12'($urandom);
        zs = 1'($urandom); rb = 5'($urandom); rd = 12'(k_rd);
        p_lct = 0; p_pad = 0;
        w.push_back(19'h0DB0A);
        w.push_back((k_badhdr == 2) ? {7'h0E, bxn} : {7'h0D, bxn});
        w.push_back({7'h0D, l1a});
        w.push_back({7'h0D, rd});
        w.push_back({4'h0, 1'(k_cfg), 2'($urandom), bxl});
        w.push_back({5'h00, (k_badhdr == 6) ? 1'b1 : 1'b0, zs, 12'($urandom)});
        w.push_back((k_badhdr == 7) ? 19'h00063 : 19'h00062);
        field = (k_nl == 0) ? 4'(k_b1) : 4'(k_nl + 1);
        w.push_back({10'h005, field, rb});
        if (k_cfg != 0) begin
            for (int i = 0; i < 44; i++) w.push_back({1'b0, 18'($urandom)});
        end
        for (int i = 0; i < 2 * k_nl; i++) begin
            d7 = 7'($urandom); lo = 4'($urandom);
            if (i + 1 == k_badlct) begin
                w.push_back({7'h00, d7, 1'b1, lo});
                p_lct = w.size();
            end else begin
                w.push_back({7'h00, d7, 1'b0, lo});
                lpos.push_back(w.size());
                lexp.push_back({d7, lo[0], lo[3:1]});
            end
        end
        if (k_nl > 0) begin
            w.push_back((k_badpad != 0) ? 19'h00001 : 19'h00000);
            if (k_badpad != 0) p_pad = w.size();
            w.push_back(19'h00000);
        end
        for (int i = 0; i < k_nraw; i++) begin
            do r = {1'b0, 18'($urandom)}; while (r == 19'h0DE0D);
            w.push_back(r);
        end
        w.push_back(19'h0DE0D);
        w.push_back({1'b0, 18'($urandom)});
        w.push_back({1'b0, 18'($urandom)});
        n = w.size() + 1;
        n11 = 11'(n);
        w.push_back({8'h3A, (k_badlast != 0) ? n11 + 11'd1 : n11});

        cut = k_cut;
        if ((k_mode != 0) && (cut == 0)) cut = $urandom_range(n, 2);
        aborted = (k_mode != 0) && (cut >= 2) && (cut <= n);
        sent = aborted ? cut - 1 : n;
        nx = m_prev + 12'd1;
        ev[0] = (k_badhdr != 0) && (k_badhdr <= sent);
        ev[1] = aborted;
        ev[2] = ((p_lct != 0) && (p_lct <= sent)) || ((p_pad != 0) && (p_pad <= sent));
        ev[3] = aborted ? (sent >= 2047) : ((k_badlast != 0) || (n > 2047));
        ev[4] = m_pvalid && (sent >= 4) && (rd != nx);
        foreach (lpos[j]) if (lpos[j] <= sent) lct_q.push_back(lexp[j]);
        if (!(aborted && (k_mode == 2))) begin
            if (m_frames != 16'hFFFF) m_frames++;
            if ((ev != 5'd0) && (m_errors != 16'hFFFF)) m_errors++;
            e.err = ev; e.wc = 11'((sent > 2047) ? 2047 : sent); e.hchk = (sent >= 8);
            e.bxn = bxn; e.l1a = l1a; e.rd = rd; e.bxl = bxl; e.cfg = 1'(k_cfg); e.zs = zs;
            e.lb = 4'(k_nl); e.rb = rb; e.fr = m_frames; e.er = m_errors;
            exp_q.push_back(e);
            if (!aborted) begin
                m_prev = rd;
                m_pvalid = 1'b1;
            end
        end

        for (int i = 0; i < sent; i++) send(w[i]);
        if (aborted && (k_mode == 1)) begin
            send(19'h40000);
        end else if (aborted && (k_mode == 2)) begin
            hard_rst = 1'b0;
            send(19'h40000);
            hard_rst = 1'b1;
            m_frames = 16'd0; m_errors = 16'd0; m_pvalid = 1'b0;
            check_reset_state("midrst");
        end
        repeat (k_gap) send(19'h40000);
    endtask

    // frame and LCT monitor, sampled away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_frame_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("err", 32'(err), 32'(e.err));
                check_val("frame_ok", 32'(frame_ok), (e.err == 5'd0) ? 32'd1 : 32'd0);
                check_val("word_cnt", 32'(word_cnt), 32'(e.wc));
                check_val("frames", 32'(frames), 32'(e.fr));
                check_val("errors", 32'(errors), 32'(e.er));
                if (e.hchk) begin
                    check_val("bxn_hdr", 32'(bxn_hdr), 32'(e.bxn));
                    check_val("l1a_cnt_hdr", 32'(l1a_cnt_hdr), 32'(e.l1a));
                    check_val("rdout_cnt_hdr", 32'(rdout_cnt_hdr), 32'(e.rd));
                    check_val("bxn_lct", 32'(bxn_lct), 32'(e.bxl));
                    check_val("cfg_rep", 32'(cfg_rep), 32'(e.cfg));
                    check_val("zero_sup", 32'(zero_sup), 32'(e.zs));
                    check_val("lct_bins", 32'(lct_bins), 32'(e.lb));
                    check_val("raw_bins", 32'(raw_bins), 32'(e.rb));
                end
            end
        end
        if (lct_we) begin
            if (lct_q.size() == 0) begin
                check_val("spurious_lct_we", 32'd1, 32'd0);
            end else begin
                check_val("lct_data", 32'(lct_data), 32'(lct_q.pop_front()));
            end
        end
    end

    initial begin
        hard_rst = 1'b0;
        daq_in = 19'h0DB0A;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        hard_rst = 1'b1;
        send(19'h40000);

        frame_defaults(12'h005);                     // minimal frame, 12 words
        run_frame();
        frame_defaults(6); k_nl = 2; k_gap = 0;      // two LCT bins, back-to-back next
        run_frame();
        frame_defaults(7); k_cfg = 1;                // config block skipped
        run_frame();
        frame_defaults(8); k_nraw = 5; k_mode = 1; k_cut = 11;   // idle on 3rd raw word
        run_frame();
        frame_defaults(8); k_nraw = 2;
        run_frame();
        frame_defaults(5); run_frame();              // continuity: 5 -> 7 breaks
        frame_defaults(7); run_frame();
        frame_defaults(8); run_frame();
        frame_defaults(12'hFFF); run_frame();
        frame_defaults(12'h000); run_frame();        // wrap-around
        frame_defaults(1); k_badlast = 1; run_frame();
        frame_defaults(2); k_badhdr = 7; k_nl = 1; k_badlct = 2; k_badpad = 1; run_frame();
        frame_defaults(3); k_nl = 3; k_mode = 2; k_cut = 11;     // reset mid-LCT
        run_frame();
        frame_defaults(9); k_nl = 1; run_frame();
        frame_defaults(10); k_nraw = 2100; run_frame(); // word-count saturation

        for (int f = 0; f < 40; f++) begin
            k_rd = ($urandom_range(4, 0) == 0) ? int'($urandom) : int'(m_prev) + 1;
            k_cfg = ($urandom_range(3, 0) == 0) ? 1 : 0;
            k_nl = $urandom_range(3, 0);
            k_b1 = $urandom_range(1, 0);
            k_nraw = $urandom_range(5, 0);
            case ($urandom_range(11, 0))
                0: k_badhdr = 2;
                1: k_badhdr = 6;
                2: k_badhdr = 7;
                default: k_badhdr = 0;
            endcase
            k_badlct = ((k_nl > 0) && ($urandom_range(5, 0) == 0)) ? $urandom_range(2 * k_nl, 1) : 0;
            k_badpad = ($urandom_range(7, 0) == 0) ? 1 : 0;
            k_badlast = ($urandom_range(7, 0) == 0) ? 1 : 0;
            k_mode = ($urandom_range(6, 0) == 0) ? 1 : 0;
            k_cut = 0;
            k_gap = $urandom_range(2, 0);
            run_frame();
        end

        repeat (4) send(19'h40000);
        check_val("pending_frames", 32'(exp_q.size()), 32'd0);
        check_val("pending_lct", 32'(lct_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
